// File: rtl/register_def_pkg.sv
// register_def_pkg: shared definitions for the register_def storage cell.
//   DEFAULT_WIDTH    : default data width of register_def.
//   PARITY_MAX_WIDTH : widest vector the parity helper accepts. Callers
//                      zero-extend narrower vectors, which leaves parity unchanged.
//   even_parity()    : even-parity bit of a vector. It is the XOR of all bits,
//                      so data plus this bit always holds an even number of ones.
package register_def_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int PARITY_MAX_WIDTH = 256;

  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] vec);
    even_parity = ^vec;
  endfunction

endpackage

// File: rtl/register_def_bit.sv
// register_def_bit: one-bit storage cell of register_def.
//   clk   : rising-edge clock
//   rst_L : synchronous reset, active-high despite its name; loads def
//   d     : data bit, loaded when en=1 and the cell is not in reset
//   en    : load enable, active-high
//   def   : default bit, loaded on reset edges
//   q     : registered contents
// Reset has priority over en. Otherwise the cell holds its value.
module register_def_bit (
  input  logic clk,
  input  logic rst_L,
  input  logic d,
  input  logic en,
  input  logic def,
  output logic q
);

  logic q_r;

  // Update the stored bit: reset loads the default, enable loads data, else hold.
  always_ff @(posedge clk) begin
    if (rst_L) begin
      q_r <= def;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/register_def.sv
// register_def: WIDTH-bit storage register with a per-instance default value.
// It is the byte cell of the memory model: def comes from the memory image,
// and D is tied to the shared data bus.
//   clk        : rising-edge clock, the only clock
//   rst_L      : synchronous reset, active-high despite the _L suffix; Q <= def
//   D          : data to load; X/Z from a floating bus are captured unchanged
//   en         : load enable, active-high; Q <= D when not in reset
//   def        : default value, sampled only on reset edges
//   Q          : registered contents, one-cycle latency, no combinational path
//   parity_err : only present when REGISTER_DEF_PARITY_EN is defined.
//                Combinational flag, 1 when the parity of Q differs from the
//                parity bit stored with the last reset or load.
// Optional build macro: REGISTER_DEF_PARITY_EN. It adds the stored even-parity
// bit and the parity_err port.
// WIDTH must be 1 or more. With parity enabled, WIDTH must also be at most
// PARITY_MAX_WIDTH.
module register_def
  import register_def_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic [WIDTH-1:0] def,
  output logic [WIDTH-1:0] Q
`ifdef REGISTER_DEF_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  logic [WIDTH-1:0] q_s;

  // One storage cell per bit. Each cell applies the reset/enable priority itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    register_def_bit u_bit (
      .clk   (clk),
      .rst_L (rst_L),
      .d     (D[i]),
      .en    (en),
      .def   (def[i]),
      .q     (q_s[i])
    );
  end

  assign Q = q_s;

`ifdef REGISTER_DEF_PARITY_EN
  logic [PARITY_MAX_WIDTH-1:0] def_ext_s;
  logic [PARITY_MAX_WIDTH-1:0] d_ext_s;
  logic [PARITY_MAX_WIDTH-1:0] q_ext_s;
  logic                        par_r;

  // Zero-extend the data vectors to the width the shared parity helper accepts.
  always_comb begin
    def_ext_s            = '0;
    d_ext_s              = '0;
    q_ext_s              = '0;
    def_ext_s[WIDTH-1:0] = def;
    d_ext_s[WIDTH-1:0]   = D;
    q_ext_s[WIDTH-1:0]   = q_s;
  end

  // Store the parity of whatever the cells capture on the same edge.
  always_ff @(posedge clk) begin
    if (rst_L) begin
      par_r <= even_parity(def_ext_s);
    end else if (en) begin
      par_r <= even_parity(d_ext_s);
    end else begin
      par_r <= par_r;
    end
  end

  // Recompute the parity from the live contents, so a flipped storage bit shows up at once.
  assign parity_err = (even_parity(q_ext_s) != par_r);
`endif

endmodule

// File: tb/tb_register_def.sv
// tb_register_def: randomized, scoreboard-checked bench for register_def.
// It drives an 8-bit, a 1-bit and a 16-bit instance. The 1-bit and 16-bit
// instances share rst_L/en with the 8-bit one, but have their own data and
// default values.
// The driver applies inputs on the falling edge and pushes the value a
// behavioural model predicts. The monitor pops one entry after each rising
// edge and compares it with Q.
// When REGISTER_DEF_PARITY_EN is defined, the bench also checks parity_err,
// including one forced bit flip.
module tb_register_def;
  import register_def_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_L = 1'b0;
  logic        en    = 1'b0;
  logic [7:0]  d8    = 8'h00;
  logic [7:0]  def8  = 8'h00;
  logic [7:0]  q8;
  logic [0:0]  d1    = 1'b0;
  logic [0:0]  def1  = 1'b0;
  logic [0:0]  q1;
  logic [15:0] d16   = 16'h0000;
  logic [15:0] def16 = 16'h0000;
  logic [15:0] q16;
`ifdef REGISTER_DEF_PARITY_EN
  logic        parity_err;
  logic        perr1;
  logic        perr16;
`endif

  register_def #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_L(rst_L), .D(d8), .en(en), .def(def8), .Q(q8)
`ifdef REGISTER_DEF_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  register_def #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_L(rst_L), .D(d1), .en(en), .def(def1), .Q(q1)
`ifdef REGISTER_DEF_PARITY_EN
    , .parity_err(perr1)
`endif
  );

  register_def #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_L(rst_L), .D(d16), .en(en), .def(def16), .Q(q16)
`ifdef REGISTER_DEF_PARITY_EN
    , .parity_err(perr16)
`endif
  );

  typedef struct {
    logic [7:0]  q8;
    logic [0:0]  q1;
    logic [15:0] q16;
    bit          chk;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  m8;
  logic [0:0]  m1;
  logic [15:0] m16;
  int          checks = 0;
  int          errors = 0;

  // Reference model: a reset edge takes the default, an enable edge takes the data,
  // and any other edge keeps the previous value.
  task automatic drive(input bit r, input bit e, input logic [7:0] d, input logic [7:0] df,
                       input logic [15:0] dd, input logic [15:0] ddf, input bit chk);
    exp_t item;
    @(negedge clk);
    rst_L = r;
    en    = e;
    d8    = d;
    def8  = df;
    d16   = dd;
    def16 = ddf;
    d1    = dd[0:0];
    def1  = ddf[0:0];
    if (r) begin
      m8 = df;
      m16 = ddf;
      m1 = ddf[0:0];
    end else if (e) begin
      m8 = d;
      m16 = dd;
      m1 = dd[0:0];
    end
    item.q8  = m8;
    item.q1  = m1;
    item.q16 = m16;
    item.chk = chk;
    sb_q.push_back(item);
  endtask

  // Monitor: pop one expectation shortly after every rising edge and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk) begin
        checks++;
        if (q8 !== e.q8) begin
          errors++;
          $display("FAIL q8: got %h expected %h at %0t", q8, e.q8, $time);
        end
        checks++;
        if (q1 !== e.q1) begin
          errors++;
          $display("FAIL q1: got %b expected %b at %0t", q1, e.q1, $time);
        end
        checks++;
        if (q16 !== e.q16) begin
          errors++;
          $display("FAIL q16: got %h expected %h at %0t", q16, e.q16, $time);
        end
`ifdef REGISTER_DEF_PARITY_EN
        checks++;
        if ({parity_err, perr1, perr16} !== 3'b000) begin
          errors++;
          $display("FAIL parity_err: got %b%b%b expected 000 at %0t",
                   parity_err, perr1, perr16, $time);
        end
`endif
      end
    end
  end

  // Watchdog: stop the run if it ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef REGISTER_DEF_PARITY_EN
    logic [PARITY_MAX_WIDTH-1:0] good_ext;
    logic [PARITY_MAX_WIDTH-1:0] bad_ext;
    logic                        exp_perr;
`endif
    int drain;
    m8  = 8'h00;
    m1  = 1'b0;
    m16 = 16'h0000;

    // Reset with en=1 in the same cycle: the default wins. The wide and
    // narrow instances take all-ones.
    drive(1'b1, 1'b1, 8'h3C, 8'hA5, 16'h1234, 16'hFFFF, 1'b1);
    // Load, then hold for five cycles while D changes. The wide and narrow
    // instances load zeros.
    drive(1'b0, 1'b1, 8'h5A, 8'hA5, 16'h0000, 16'hFFFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'hFF, 8'hA5, 16'hFFFF, 16'hFFFF, 1'b1);
    end
    // Changing def outside reset has no effect. The next reset picks up the new value.
    drive(1'b0, 1'b0, 8'hFF, 8'h11, 16'hFFFF, 16'h0F0F, 1'b1);
    drive(1'b0, 1'b0, 8'hFF, 8'h11, 16'hFFFF, 16'h0F0F, 1'b1);
    drive(1'b1, 1'b0, 8'hFF, 8'h11, 16'hFFFF, 16'h0F0F, 1'b1);
    // Back-to-back loads.
    drive(1'b0, 1'b1, 8'h01, 8'h11, 16'h0001, 16'h0F0F, 1'b1);
    drive(1'b0, 1'b1, 8'h02, 8'h11, 16'h0002, 16'h0F0F, 1'b1);
    drive(1'b0, 1'b1, 8'h03, 8'h11, 16'h0003, 16'h0F0F, 1'b1);
    // Reset held for several cycles tracks def every cycle.
    drive(1'b1, 1'b0, 8'h00, 8'h22, 16'h0000, 16'hAAAA, 1'b1);
    drive(1'b1, 1'b1, 8'h77, 8'h33, 16'h7777, 16'h5555, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 8'h44, 16'h0000, 16'hFFFF, 1'b1);

`ifdef REGISTER_DEF_PARITY_EN
    // Load 07, then flip bit 0 of the stored value and expect a parity error.
    drive(1'b0, 1'b1, 8'h07, 8'h44, 16'h0007, 16'hFFFF, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h44, 16'h0000, 16'hFFFF, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h44, 16'h0000, 16'hFFFF, 1'b0);
    force dut8.g_bits[0].u_bit.q_r = 1'b0;
    #1;
    good_ext      = '0;
    bad_ext       = '0;
    good_ext[7:0] = 8'h07;
    bad_ext[7:0]  = 8'h06;
    exp_perr      = (even_parity(bad_ext) != even_parity(good_ext));
    checks++;
    if (parity_err !== exp_perr) begin
      errors++;
      $display("FAIL parity_flip: got %b expected %b", parity_err, exp_perr);
    end
    release dut8.g_bits[0].u_bit.q_r;
    drive(1'b0, 1'b0, 8'h00, 8'h44, 16'h0000, 16'hFFFF, 1'b0);
    // A reset with def=00 clears the error again.
    drive(1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1);
`endif

    // Randomized traffic, with reset asserted about one cycle in ten.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
            8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    end

    // Let the monitor catch up, but only for a bounded number of cycles.
    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
